// File: rtl/cdb_writer.sv
// Common data bus writer: per-port one-entry result slots, round-robin arbitration
// onto per-tag result registers, a one-cycle broadcast and a sticky overflow flag.
module cdb_writer #(
    parameter int NUM_RS = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RS-1:0]        req,
    input  logic [NUM_RS-1:0][2:0]   req_tag,
    input  logic [NUM_RS-1:0][31:0]  req_data,
    output logic [NUM_RS-1:0]        port_ready,
    input  logic [7:0]               allocated_rob_entries,
    input  logic                     commit_valid,
    input  logic [2:0]               commit_tag,
    input  logic                     flush,
    output logic [7:0][31:0]         cdb,
    output logic [7:0]               robs_calculated,
    output logic                     bc_valid,
    output logic [2:0]               bc_tag,
    output logic [31:0]              bc_data,
    output logic                     overflow
);

    localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic [NUM_RS-1:0]       slot_valid_r;
    logic [NUM_RS-1:0][2:0]  slot_tag_r;
    logic [NUM_RS-1:0][31:0] slot_data_r;
    logic [PW-1:0]           rr_ptr_r;

    logic          grant_valid_s;
    logic [PW-1:0] grant_idx_s;
    logic [PW-1:0] next_ptr_s;
    logic [2:0]    grant_tag_s;
    logic [31:0]   grant_data_s;
    logic          write_s;

    // (base + off) mod NUM_RS for off < NUM_RS
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_RS) begin
            s = s - NUM_RS;
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    assign port_ready = ~slot_valid_r;

    // Round-robin search for the first occupied slot at or above rr_ptr
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            if (!grant_valid_s && slot_valid_r[wrap_add(rr_ptr_r, k)]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = wrap_add(rr_ptr_r, k);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        next_ptr_s   = wrap_add(grant_idx_s, 1);
        grant_tag_s  = slot_tag_r[grant_idx_s];
        grant_data_s = slot_data_r[grant_idx_s];
        write_s      = grant_valid_s & allocated_rob_entries[grant_tag_s];
    end

    // Slot capture, arbitration, result registers, broadcast and overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid_r    <= '0;
            slot_tag_r      <= '0;
            slot_data_r     <= '0;
            rr_ptr_r        <= '0;
            cdb             <= '0;
            robs_calculated <= 8'h00;
            bc_valid        <= 1'b0;
            bc_tag          <= 3'd0;
            bc_data         <= 32'h0000_0000;
            overflow        <= 1'b0;
        end else if (flush) begin
            slot_valid_r    <= '0;
            robs_calculated <= 8'h00;
            bc_valid        <= 1'b0;
        end else begin
            // Captures only land in empty slots, so they never collide with the grant clear
            for (int i = 0; i < NUM_RS; i++) begin
                if (req[i] && !slot_valid_r[i]) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_tag_r[i]   <= req_tag[i];
                    slot_data_r[i]  <= req_data[i];
                end else if (grant_valid_s && (grant_idx_s == PW'(i))) begin
                    slot_valid_r[i] <= 1'b0;
                end else begin
                    slot_valid_r[i] <= slot_valid_r[i];
                end
            end
            overflow <= overflow | (|(req & slot_valid_r));
            if (grant_valid_s) begin
                rr_ptr_r <= next_ptr_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (commit_valid) begin
                robs_calculated[commit_tag] <= 1'b0;
            end else begin
                robs_calculated <= robs_calculated;
            end
            // Placed after the commit so a same-tag write leaves the bit set
            bc_valid <= write_s;
            if (write_s) begin
                cdb[grant_tag_s]             <= grant_data_s;
                robs_calculated[grant_tag_s] <= 1'b1;
                bc_tag                       <= grant_tag_s;
                bc_data                      <= grant_data_s;
            end else begin
                bc_tag  <= bc_tag;
                bc_data <= bc_data;
            end
        end
    end

endmodule

// File: tb/tb_cdb_writer.sv
// Self-checking bench for cdb_writer: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of slots, arbiter and tag registers.
module tb_cdb_writer;

    localparam int N = 5;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req;
    logic [N-1:0][2:0]  req_tag;
    logic [N-1:0][31:0] req_data;
    logic [N-1:0]       port_ready;
    logic [7:0]         allocated_rob_entries;
    logic               commit_valid;
    logic [2:0]         commit_tag;
    logic               flush;
    logic [7:0][31:0]   cdb;
    logic [7:0]         robs_calculated;
    logic               bc_valid;
    logic [2:0]         bc_tag;
    logic [31:0]        bc_data;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_sv [N];
    logic [2:0]  m_st [N];
    logic [31:0] m_sd [N];
    int          m_rr;
    logic [31:0] m_cdb [8];
    logic [7:0]  m_robs;
    logic        m_bcv;
    logic [2:0]  m_bct;
    logic [31:0] m_bcd;
    logic        m_ovf;

    cdb_writer #(.NUM_RS(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tag(req_tag), .req_data(req_data),
        .port_ready(port_ready), .allocated_rob_entries(allocated_rob_entries),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
        .cdb(cdb), .robs_calculated(robs_calculated), .bc_valid(bc_valid),
        .bc_tag(bc_tag), .bc_data(bc_data), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update();
        logic gv;
        int g;
        logic [2:0] gt;
        logic [31:0] gd;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin m_sv[i] = 1'b0; m_st[i] = 3'd0; m_sd[i] = 32'd0; end
            for (int t = 0; t < 8; t++) m_cdb[t] = 32'd0;
            m_rr = 0; m_robs = 8'h00; m_bcv = 1'b0; m_bct = 3'd0; m_bcd = 32'd0; m_ovf = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < N; i++) m_sv[i] = 1'b0;
            m_robs = 8'h00;
            m_bcv = 1'b0;
        end else begin
            gv = 1'b0; g = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (!gv && m_sv[idx]) begin gv = 1'b1; g = idx; end
            end
            gt = m_st[g]; gd = m_sd[g];
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_sv[i]) m_ovf = 1'b1;
                    else begin m_sv[i] = 1'b1; m_st[i] = req_tag[i]; m_sd[i] = req_data[i]; end
                end
            end
            if (gv) begin m_sv[g] = 1'b0; m_rr = (g + 1) % N; end
            if (commit_valid) m_robs[commit_tag] = 1'b0;
            m_bcv = 1'b0;
            if (gv && allocated_rob_entries[gt]) begin
                m_cdb[gt] = gd; m_robs[gt] = 1'b1; m_bcv = 1'b1; m_bct = gt; m_bcd = gd;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b1; req = '0; req_tag = '0; req_data = '0;
        commit_valid = 1'b0; commit_tag = 3'd0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        allocated_rob_entries = 8'hFF;
        rst = 1'b0; flush = 1'b1; req = 5'b11111; commit_valid = 1'b1;
        step();
        checks++; if (port_ready !== 5'b11111) begin errors++; $display("FAIL reset_ready got %b want 11111", port_ready); end
        checks++; if (robs_calculated !== 8'h00) begin errors++; $display("FAIL reset_robs got %h want 00", robs_calculated); end
        checks++; if ({bc_valid, bc_tag, bc_data} !== 36'd0) begin errors++; $display("FAIL reset_bc got %b %d %h want 0", bc_valid, bc_tag, bc_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (cdb !== 256'd0) begin errors++; $display("FAIL reset_cdb got %h want 0", cdb); end
        idle_inputs();
        step();
    endtask

    task automatic test_single();
        req[2] = 1'b1; req_tag[2] = 3'd5; req_data[2] = 32'hDEADBEEF;
        step();
        idle_inputs();
        checks++; if (port_ready !== 5'b11011) begin errors++; $display("FAIL single_capture got %b want 11011", port_ready); end
        step();
        checks++; if (cdb[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_cdb got %h want deadbeef", cdb[5]); end
        checks++; if (robs_calculated !== 8'h20) begin errors++; $display("FAIL single_robs got %h want 20", robs_calculated); end
        checks++; if ({bc_valid, bc_tag, bc_data} !== {1'b1, 3'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL single_bc got %b %d %h want 1 5 deadbeef", bc_valid, bc_tag, bc_data); end
        step();
        checks++; if (bc_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", bc_valid); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_tag [3];
        logic [4:0] exp_rdy [3];
        // One grant on port 0 moves the pointer to 1
        req[0] = 1'b1; req_tag[0] = 3'd0; req_data[0] = 32'h0000_0A00;
        step(); idle_inputs(); step();
        req = 5'b01011;
        req_tag[0] = 3'd2; req_data[0] = 32'h1111_0000;
        req_tag[1] = 3'd1; req_data[1] = 32'h1111_0001;
        req_tag[3] = 3'd3; req_data[3] = 32'h1111_0003;
        step(); idle_inputs();
        checks++; if (port_ready !== 5'b10100) begin errors++; $display("FAIL contention_capture got %b want 10100", port_ready); end
        exp_tag[0] = 3'd1; exp_tag[1] = 3'd3; exp_tag[2] = 3'd2;
        exp_rdy[0] = 5'b10110; exp_rdy[1] = 5'b11110; exp_rdy[2] = 5'b11111;
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (bc_valid !== 1'b1 || bc_tag !== exp_tag[s] || port_ready !== exp_rdy[s]) begin
                errors++;
                $display("FAIL contention_order%0d got v=%b tag=%0d rdy=%b want v=1 tag=%0d rdy=%b", s, bc_valid, bc_tag, port_ready, exp_tag[s], exp_rdy[s]);
            end
        end
    endtask

    task automatic test_overflow();
        req = 5'b00111;
        req_tag[0] = 3'd7; req_data[0] = 32'hAAAA_0007;
        req_tag[1] = 3'd1; req_data[1] = 32'hAAAA_0001;
        req_tag[2] = 3'd2; req_data[2] = 32'hAAAA_0002;
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %b want 0", overflow); end
        idle_inputs();
        req[0] = 1'b1; req_tag[0] = 3'd7; req_data[0] = 32'hBBBB_0007;
        step(); idle_inputs();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", overflow); end
        step(); step(); step();
        checks++; if (cdb[7] !== 32'hAAAA_0007) begin errors++; $display("FAIL overflow_dropped got %h want aaaa0007", cdb[7]); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_hold got %b want 1", overflow); end
    endtask

    task automatic test_unalloc();
        allocated_rob_entries = 8'hEF;
        req[3] = 1'b1; req_tag[3] = 3'd4; req_data[3] = 32'hCAFE_0004;
        step(); idle_inputs(); step();
        checks++; if (bc_valid !== 1'b0 || robs_calculated[4] !== 1'b0 || cdb[4] !== 32'd0) begin
            errors++; $display("FAIL unalloc got v=%b robs4=%b cdb4=%h want 0 0 0", bc_valid, robs_calculated[4], cdb[4]);
        end
        checks++; if (port_ready !== 5'b11111) begin errors++; $display("FAIL unalloc_free got %b want 11111", port_ready); end
        allocated_rob_entries = 8'hFF;
    endtask

    task automatic test_commit();
        req[1] = 1'b1; req_tag[1] = 3'd6; req_data[1] = 32'h6666_6666;
        step(); idle_inputs();
        commit_valid = 1'b1; commit_tag = 3'd6;
        step();
        checks++; if (robs_calculated[6] !== 1'b1 || cdb[6] !== 32'h6666_6666) begin
            errors++; $display("FAIL commit_collision got bit=%b cdb=%h want 1 66666666", robs_calculated[6], cdb[6]);
        end
        commit_tag = 3'd5;
        step(); idle_inputs();
        checks++; if (robs_calculated[5] !== 1'b0 || cdb[5] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL commit_clear got bit=%b cdb=%h want 0 deadbeef", robs_calculated[5], cdb[5]);
        end
    endtask

    task automatic test_flush();
        logic [7:0][31:0] snap;
        req = 5'b10010;
        req_tag[1] = 3'd3; req_data[1] = 32'hF1F1_0003;
        req_tag[4] = 3'd4; req_data[4] = 32'hF1F1_0004;
        step(); idle_inputs();
        checks++; if (port_ready !== 5'b01101) begin errors++; $display("FAIL flush_pending got %b want 01101", port_ready); end
        snap = cdb;
        flush = 1'b1; req[0] = 1'b1; req_data[0] = 32'h0BAD_0BAD; commit_valid = 1'b1;
        step(); idle_inputs();
        checks++; if (port_ready !== 5'b11111 || robs_calculated !== 8'h00 || bc_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got rdy=%b robs=%h v=%b want 11111 00 0", port_ready, robs_calculated, bc_valid);
        end
        step();
        checks++; if (cdb !== snap || bc_valid !== 1'b0 || robs_calculated !== 8'h00) begin
            errors++; $display("FAIL flush_hold got cdb=%h v=%b robs=%h want cdb=%h 0 00", cdb, bc_valid, robs_calculated, snap);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] exp_rdy;
            idle_inputs();
            rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
            flush = ($urandom_range(0, 24) == 0);
            req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_tag[i] = 3'($urandom);
                req_data[i] = $urandom;
            end
            allocated_rob_entries = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            commit_valid = ($urandom_range(0, 2) == 0);
            commit_tag = 3'($urandom);
            for (int i = 0; i < N; i++) exp_rdy[i] = ~m_sv[i];
            checks++; if (port_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, port_ready, exp_rdy); end
            step();
            checks++; if (robs_calculated !== m_robs) begin errors++; $display("FAIL rand_robs c%0d got %h want %h", c, robs_calculated, m_robs); end
            checks++; if ({bc_valid, bc_tag, bc_data} !== {m_bcv, m_bct, m_bcd}) begin
                errors++; $display("FAIL rand_bc c%0d got %b %0d %h want %b %0d %h", c, bc_valid, bc_tag, bc_data, m_bcv, m_bct, m_bcd);
            end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow c%0d got %b want %b", c, overflow, m_ovf); end
            for (int t = 0; t < 8; t++) begin
                checks++; if (cdb[t] !== m_cdb[t]) begin errors++; $display("FAIL rand_cdb c%0d tag%0d got %h want %h", c, t, cdb[t], m_cdb[t]); end
            end
        end
    endtask

    initial begin
        idle_inputs();
        allocated_rob_entries = 8'hFF;
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_unalloc();
        test_commit();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_writer.md
CDB_WRITER -- requirements
Module: cdb_writer

Interface
REQ-001 Parameter NUM_RS, default 5, number of reservation-station result ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 req  input  NUM_RS  per-port result request from a reservation station/ALU pair.
REQ-005 req_tag  input  NUM_RS x 3  destination ROB tag per port.
REQ-006 req_data  input  NUM_RS x 32  result data per port (ALU output or PC-derived value).
REQ-007 port_ready  output  NUM_RS  port slot empty; the request is accepted this cycle.
REQ-008 allocated_rob_entries  input  8  ROB entries currently allocated.
REQ-009 commit_valid, commit_tag  input  1, 3  ROB retiring entry commit_tag.
REQ-010 flush  input  1  pipeline flush.
REQ-011 cdb  output  8 x cdb_data  per-tag result registers read by reservation stations.
REQ-012 robs_calculated  output  8  bit t set = cdb[t].data valid.
REQ-013 bc_valid, bc_tag, bc_data  output  1, 3, 32  registered one-cycle broadcast of the latest write.
REQ-014 overflow  output  1  sticky error; a request arrived while its port was not ready.

Function
REQ-015 Each port SHALL own a one-entry slot (valid, tag, data); port_ready[i] SHALL equal ~slot_valid[i].
REQ-016 When req[i] and port_ready[i] are both high at a rising edge, slot i SHALL capture req_tag[i] and req_data[i].
REQ-017 When req[i] is high and port_ready[i] is low, the request SHALL be dropped and overflow SHALL set and hold until reset.
REQ-018 A round-robin arbiter SHALL grant at most one occupied slot per cycle, searching upward from rr_ptr with wrap at NUM_RS.
REQ-019 After a grant to slot g, rr_ptr SHALL become (g+1) mod NUM_RS; with no grant, rr_ptr SHALL hold.
REQ-020 A granted slot SHALL clear at the same edge that its result is written.
REQ-021 Grant of slot g carrying tag t with allocated_rob_entries[t]=1 SHALL, at the next edge, set cdb[t].data=data, robs_calculated[t]=1, bc_valid=1, bc_tag=t, bc_data=data.
REQ-022 Grant with allocated_rob_entries[t]=0 SHALL discard the result: slot cleared, no cdb/robs_calculated change, bc_valid=0.
REQ-023 Latency: req at edge N captured; earliest cdb/robs_calculated update at edge N+1 when uncontended; worst case N+NUM_RS.
REQ-024 bc_valid SHALL be a single-cycle pulse per write and low in every cycle without a write.
REQ-025 commit_valid SHALL clear robs_calculated[commit_tag] at the edge; cdb[commit_tag].data SHALL be retained.
REQ-026 Simultaneous write and commit to the same tag: the write SHALL win (bit ends set).
REQ-027 flush SHALL at the edge clear all slots, robs_calculated, and bc_valid; requests in the flush cycle SHALL be ignored; cdb data, rr_ptr, and overflow SHALL hold.
REQ-028 flush SHALL take priority over grant, capture, and commit in the same cycle.
REQ-029 Two slots holding the same tag SHALL each be written in grant order; the last write SHALL remain in cdb.

Reset
REQ-030 On rst=0 at an edge: slots empty, port_ready all 1, robs_calculated=0, cdb[*].data=0, bc_valid=0, bc_tag=0, bc_data=0, rr_ptr=0, overflow=0.
REQ-031 Reset SHALL override flush, capture, and commit in the same cycle; mid-operation reset SHALL discard pending slots.

Verification
REQ-032 Single request: port 2, tag 5, data 0xDEADBEEF, allocated=0xFF -> next edge cdb[5]=0xDEADBEEF, robs_calculated=0x20, bc_valid one cycle.
REQ-033 Contention: ports 0,1,3 request in the same cycle, rr_ptr=1 -> writes in order 1,3,0 on consecutive edges; port_ready bits return high in that order.
REQ-034 Overflow: port 0 requests for 2 consecutive cycles while blocked by higher-priority traffic -> second request dropped, overflow=1 and held.
REQ-035 Unallocated tag: tag 4 with allocated_rob_entries[4]=0 -> no cdb change, robs_calculated[4]=0, bc_valid=0, slot freed.
REQ-036 Commit/write collision and flush: write and commit of tag 6 in the same cycle -> bit 6 set; then flush with 2 slots pending -> slots empty, robs_calculated=0, cdb data unchanged.
